// File: rtl/dv_stim_pkg.sv
// Shared types and helpers for the DV stimulus controller.
//
// Contents:
//   state_t        controller states (RESET, ACTIVE, SEND, DRAIN, DONE)
//   LFSR_TAPS_*    Galois LFSR tap masks for 8/16/32/64-bit payloads
//   lfsr_taps()    tap mask lookup by payload width
//   next_payload() next value of the payload sequence
//
// Build option: DV_STIM_LFSR_EN
//   defined     -> the payload sequence is a Galois LFSR
//   not defined -> the payload sequence increments by one
// In both cases the value wraps modulo 2^pw.
package dv_stim_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_SEND   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Right-shifting Galois form, maximal-length polynomials.
  localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  // Widths without a table entry get a single MSB tap. The result is a
  // plain rotate, which is deterministic but not maximal length.
  function automatic logic [63:0] lfsr_taps(input int unsigned pw);
    case (pw)
      8:       return LFSR_TAPS_8;
      16:      return LFSR_TAPS_16;
      32:      return LFSR_TAPS_32;
      64:      return LFSR_TAPS_64;
      default: return 64'd1 << (pw - 1);
    endcase
  endfunction

  // Works on a 64-bit container. Only the low pw bits are meaningful.
  function automatic logic [63:0] next_payload(input logic [63:0] cur,
                                               input int unsigned pw);
    logic [63:0] mask;
    logic [63:0] nxt;
    mask = (pw >= 64) ? '1 : ((64'd1 << pw) - 64'd1);
`ifdef DV_STIM_LFSR_EN
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ lfsr_taps(pw);
`else
    nxt = cur + 64'd1;
`endif
    return nxt & mask;
  endfunction

endpackage

// File: rtl/dv_stim_ctrl_if.sv
// Stimulus/response bus between the stimulus controller and the DUT.
//
// Signals:
//   stim_access  controller -> DUT  packet valid
//   stim_packet  controller -> DUT  packet payload (PW bits)
//   stim_wait    DUT -> controller  backpressure
//   resp_access  DUT -> controller  response valid (cannot be stalled)
//   resp_packet  DUT -> controller  response payload (PW bits)
//
// Handshake: a packet transfers on a rising clk edge where stim_access=1
// and stim_wait=0. While stim_access=1 and stim_wait=1, stim_packet holds
// its value and stim_access stays high. A response is taken on every edge
// where resp_access=1; there is no backpressure on the response side.
//
// Modports: master = stimulus controller, slave = DUT side.
interface dv_stim_ctrl_if #(
  parameter int PW = 32
);
  logic          stim_access;
  logic [PW-1:0] stim_packet;
  logic          stim_wait;
  logic          resp_access;
  logic [PW-1:0] resp_packet;

  modport master (
    output stim_access, stim_packet,
    input  stim_wait, resp_access, resp_packet
  );

  modport slave (
    input  stim_access, stim_packet,
    output stim_wait, resp_access, resp_packet
  );
endinterface

// File: rtl/dv_stim_gen.sv
// Registered payload generator. It holds the current payload, which comes
// out of reset as SEED, and it steps to the next value on each cycle that
// advance_i is high.
//
// Ports:
//   clk        clock
//   nreset     async active-low reset (payload returns to SEED)
//   advance_i  step to the next payload at the next edge
//   payload_o  current payload (PW bits)
//
// The sequence follows dv_stim_pkg::next_payload(). That function is an
// LFSR when DV_STIM_LFSR_EN is defined and an increment otherwise.
// PW is supported from 8 to 64 bits.
module dv_stim_gen
  import dv_stim_pkg::*;
#(
  parameter int            PW   = 32,
  parameter logic [PW-1:0] SEED = PW'(1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          advance_i,
  output logic [PW-1:0] payload_o
);

  logic [PW-1:0] payload_q;
  logic [PW-1:0] payload_d;
  // Bits above PW are always zero after masking and are ignored here.
  logic [63:0]   next_wide_unused;

  assign next_wide_unused = next_payload(64'(payload_q), PW);
  assign payload_d        = advance_i ? next_wide_unused[PW-1:0] : payload_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) payload_q <= SEED;
    else         payload_q <= payload_d;
  end

  assign payload_o = payload_q;

endmodule

// File: rtl/dv_stim_ctrl.sv
// Testbench-side stimulus controller. It runs after the DV control block.
// It waits out a reset period and then reports dut_active. When start is
// seen, it sends N packets to the DUT over the access/wait handshake. It
// checks each in-order response against a second copy of the payload
// generator and reports the outcome.
//
// Ports:
//   clk, nreset   clock, async active-low reset
//   start         level start from DV control (sampled in ACTIVE only)
//   bus           dv_stim_ctrl_if.master (stim_* out, stim_wait/resp_* in)
//   dut_active    reset period complete
//   stim_done     all N packets accepted by the DUT
//   test_done     test finished, pass or fail (sticky)
//   test_fail     mismatch, extra response or timeout (sticky)
//   err_count     saturating count of mismatches and extra responses
//   dbg_state_o   current controller state
//
// Build option: DV_STIM_LFSR_EN selects an LFSR payload sequence (see
// dv_stim_pkg). The checker behaves the same in both builds.
module dv_stim_ctrl
  import dv_stim_pkg::*;
#(
  parameter int            PW         = 32,
  parameter int            N          = 16,
  parameter int            RST_CYCLES = 16,
  parameter int            TIMEOUT    = 1000,
  parameter logic [PW-1:0] SEED       = PW'(32'h1)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  start,
  dv_stim_ctrl_if.master        bus,
  output logic                  dut_active,
  output logic                  stim_done,
  output logic                  test_done,
  output logic                  test_fail,
  output logic [15:0]           err_count,
  output state_t                dbg_state_o
);

  localparam int CW = (N < 1) ? 1 : $clog2(N + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int RW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);

  localparam logic [CW-1:0] N_C      = CW'(N);
  localparam logic [CW-1:0] N_LAST   = CW'((N > 0) ? N - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  state_t        state_q;
  logic [RW-1:0] rst_cnt_q;
  logic          access_q;
  logic [CW-1:0] tx_cnt_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          dut_active_q, stim_done_q, test_done_q, test_fail_q;
  logic [15:0]   err_cnt_q;

  logic [PW-1:0] tx_payload;
  logic [PW-1:0] exp_payload;

  logic xfer, resp, in_run, resp_ok, resp_mis, err_inc;
  logic tx_last, rx_all, to_hit;

  // Transmit sequence: steps only when the DUT accepts a packet.
  dv_stim_gen #(.PW(PW), .SEED(SEED)) u_tx_gen (
    .clk       (clk),
    .nreset    (nreset),
    .advance_i (xfer),
    .payload_o (tx_payload)
  );

  // Expected sequence: steps on every response, so the responses stay in
  // order with the packets.
  dv_stim_gen #(.PW(PW), .SEED(SEED)) u_exp_gen (
    .clk       (clk),
    .nreset    (nreset),
    .advance_i (bus.resp_access),
    .payload_o (exp_payload)
  );

  always_comb begin
    xfer     = access_q & ~bus.stim_wait;
    resp     = bus.resp_access;
    in_run   = (state_q == ST_SEND) || (state_q == ST_DRAIN);
    // A response is expected only in SEND/DRAIN and only while fewer than
    // N have arrived. Any other response counts as an extra.
    resp_ok  = resp && in_run && (rx_cnt_q != N_C);
    resp_mis = resp_ok && (bus.resp_packet != exp_payload);
    err_inc  = (resp && !resp_ok) || resp_mis;
    rx_cnt_d = rx_cnt_q + CW'(resp_ok);
    // This includes a response taken in the same cycle.
    rx_all   = (rx_cnt_d == N_C);
    tx_last  = (tx_cnt_q == N_LAST);

    to_cnt_d = to_cnt_q;
    if (xfer || resp) to_cnt_d = '0;
    else if (in_run)  to_cnt_d = to_cnt_q + 1'b1;
    to_hit   = in_run && !(xfer || resp) && (to_cnt_q == TO_LAST);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_RESET;
      rst_cnt_q    <= '0;
      access_q     <= 1'b0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      to_cnt_q     <= '0;
      dut_active_q <= 1'b0;
      stim_done_q  <= 1'b0;
      test_done_q  <= 1'b0;
      test_fail_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      to_cnt_q <= to_cnt_d;
      if (xfer) tx_cnt_q <= tx_cnt_q + 1'b1;

      if (err_inc) begin
        test_fail_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end

      case (state_q)
        ST_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q      <= ST_ACTIVE;
            dut_active_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (start) begin
            if (N == 0) begin
              state_q     <= ST_DONE;
              stim_done_q <= 1'b1;
              test_done_q <= 1'b1;
            end else begin
              state_q <= ST_SEND;
            end
          end
        end

        ST_SEND: begin
          if (xfer && tx_last) begin
            access_q    <= 1'b0;
            stim_done_q <= 1'b1;
            if (rx_all) begin
              state_q     <= ST_DONE;
              test_done_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (to_hit) begin
            access_q    <= 1'b0;
            state_q     <= ST_DONE;
            test_done_q <= 1'b1;
            test_fail_q <= 1'b1;
          end else begin
            // access stays low only in the first SEND cycle.
            access_q <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (rx_all) begin
            state_q     <= ST_DONE;
            test_done_q <= 1'b1;
          end else if (to_hit) begin
            state_q     <= ST_DONE;
            test_done_q <= 1'b1;
            test_fail_q <= 1'b1;
          end
        end

        ST_DONE: ;

        default: state_q <= ST_RESET;
      endcase
    end
  end

  // The payload shows on the bus only while a packet is offered, so
  // stim_packet reads 0 in reset and between tests.
  assign bus.stim_access = access_q;
  assign bus.stim_packet = access_q ? tx_payload : '0;
  assign dut_active      = dut_active_q;
  assign stim_done       = stim_done_q;
  assign test_done       = test_done_q;
  assign test_fail       = test_fail_q;
  assign err_count       = err_cnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_dv_stim_ctrl.sv
// Directed bench for dv_stim_ctrl. Instance A (N=16, TIMEOUT=50, wrapping
// seed) is driven by a registered loopback DUT model. Instance B (N=0)
// covers the empty test.
module tb_dv_stim_ctrl;
  import dv_stim_pkg::*;

  localparam logic [31:0] SEED_A = 32'hFFFF_FFF8;
  localparam int          N_A    = 16;

  logic clk;
  logic nreset_a, start_a, nreset_b, start_b;
  logic dut_active_a, stim_done_a, test_done_a, test_fail_a;
  logic dut_active_b, stim_done_b, test_done_b, test_fail_b;
  logic [15:0] err_count_a, err_count_b;
  state_t state_a, state_b;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  dv_stim_ctrl_if #(.PW(32)) bus_a ();
  dv_stim_ctrl_if #(.PW(32)) bus_b ();

  dv_stim_ctrl #(.PW(32), .N(N_A), .RST_CYCLES(16), .TIMEOUT(50), .SEED(SEED_A)) u_dut_a (
    .clk(clk), .nreset(nreset_a), .start(start_a), .bus(bus_a),
    .dut_active(dut_active_a), .stim_done(stim_done_a), .test_done(test_done_a),
    .test_fail(test_fail_a), .err_count(err_count_a), .dbg_state_o(state_a)
  );

  dv_stim_ctrl #(.PW(32), .N(0), .RST_CYCLES(4), .TIMEOUT(50), .SEED(32'h1)) u_dut_b (
    .clk(clk), .nreset(nreset_b), .start(start_b), .bus(bus_b),
    .dut_active(dut_active_b), .stim_done(stim_done_b), .test_done(test_done_b),
    .test_fail(test_fail_b), .err_count(err_count_b), .dbg_state_o(state_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset_a();
    nreset_a = 1'b0;
    start_a  = 1'b1;
    bus_a.stim_wait   = 1'b0;
    bus_a.resp_access = 1'b0;
    bus_a.resp_packet = '0;
    repeat (2) @(posedge clk);
    #1 nreset_a = 1'b1;
  endtask

  // ---------------- driver + scoreboard ----------------
  // Registered loopback model of the DUT. Each transfer is answered one
  // cycle later. It can stall packet wait_at for wait_len cycles, corrupt
  // response corrupt_at, drop response drop_at, or pull reset once
  // abort_at packets have transferred.
  task automatic run_traffic(input int wait_at, input int wait_len, input int corrupt_at,
                             input int drop_at, input int abort_at,
                             output int tx, output int fa_cyc, output int sd_cyc,
                             output int td_cyc);
    logic        xfer;
    logic [31:0] last_d;
    logic [31:0] exp_v;
    int          wait_left;
    bit          wait_done;
    tx = 0; fa_cyc = -1; sd_cyc = -1; td_cyc = -1;
    wait_left = 0; wait_done = 0; last_d = '0;
    exp_q.delete();
    for (int i = 0; i < N_A; i++) exp_q.push_back(SEED_A + 32'(i));
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      xfer = bus_a.stim_access && !bus_a.stim_wait;
      if (bus_a.stim_access && fa_cyc < 0) fa_cyc = cyc;
      if (bus_a.stim_access && bus_a.stim_wait && exp_q.size() > 0) begin
        n_checks++;
        if (bus_a.stim_packet !== exp_q[0])
          $display("FAIL hold_packet: got %0h expected %0h", bus_a.stim_packet, exp_q[0]);
        else n_pass++;
      end
      if (xfer) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_transfer: got packet %0h expected no transfer", bus_a.stim_packet);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus_a.stim_packet !== exp_v)
            $display("FAIL tx_payload[%0d]: got %0h expected %0h", tx, bus_a.stim_packet, exp_v);
          else n_pass++;
        end
        last_d = bus_a.stim_packet;
        tx++;
      end
      if (stim_done_a && sd_cyc < 0) sd_cyc = cyc;
      if (test_done_a) begin
        td_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      bus_a.resp_access = xfer && ((tx - 1) != drop_at);
      bus_a.resp_packet = (xfer && (tx - 1) == corrupt_at) ? (last_d ^ 32'h1) : last_d;
      if (tx == wait_at && !wait_done) begin
        wait_left = wait_len;
        wait_done = 1;
      end
      bus_a.stim_wait = (wait_left > 0);
      if (wait_left > 0) wait_left--;
      if (abort_at >= 0 && tx == abort_at) begin
        nreset_a = 1'b0;
        break;
      end
    end
    bus_a.resp_access = 1'b0;
    bus_a.stim_wait   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first;
    nreset_a = 1'b0;
    start_a  = 1'b1;
    bus_a.stim_wait = 1'b0; bus_a.resp_access = 1'b0; bus_a.resp_packet = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_a.stim_access, dut_active_a, stim_done_a, test_done_a, test_fail_a} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000",
               {bus_a.stim_access, dut_active_a, stim_done_a, test_done_a, test_fail_a});
    else n_pass++;
    n_checks++;
    if (bus_a.stim_packet !== 32'h0 || err_count_a !== 16'h0)
      $display("FAIL reset_data: got packet %0h err %0h expected 0 0", bus_a.stim_packet, err_count_a);
    else n_pass++;
    n_checks++;
    if (state_a !== ST_RESET) $display("FAIL reset_state: got %0d expected %0d", state_a, ST_RESET);
    else n_pass++;
    nreset_a = 1'b1;
    first = -1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (dut_active_a && first < 0) first = k;
    end
    n_checks++;
    if (first != 16) $display("FAIL dut_active_cycle: got %0d expected 16", first);
    else n_pass++;
    n_checks++;
    if (dut_active_a !== 1'b1) $display("FAIL dut_active_sticky: got %b expected 1", dut_active_a);
    else n_pass++;
  endtask

  task automatic test_basic();
    int tx, fa, sd, td;
    apply_reset_a();
    run_traffic(-1, 0, -1, -1, -1, tx, fa, sd, td);
    n_checks++;
    if (tx != 16 || td < 0) $display("FAIL basic_count: got tx %0d done_cyc %0d expected 16 >=0", tx, td);
    else n_pass++;
    n_checks++;
    if (sd - fa != 16) $display("FAIL basic_back_to_back: got %0d cycles expected 16", sd - fa);
    else n_pass++;
    n_checks++;
    if ({stim_done_a, test_done_a, test_fail_a, bus_a.stim_access} !== 4'b1100)
      $display("FAIL basic_flags: got %b expected 1100",
               {stim_done_a, test_done_a, test_fail_a, bus_a.stim_access});
    else n_pass++;
    n_checks++;
    if (err_count_a !== 16'd0 || state_a !== ST_DONE)
      $display("FAIL basic_end: got err %0d state %0d expected 0 %0d", err_count_a, state_a, ST_DONE);
    else n_pass++;
    // A response after completion is an extra response.
    @(posedge clk); #1;
    bus_a.resp_access = 1'b1;
    bus_a.resp_packet = 32'h1234_5678;
    @(posedge clk); #1;
    bus_a.resp_access = 1'b0;
    n_checks++;
    if (err_count_a !== 16'd1 || test_fail_a !== 1'b1)
      $display("FAIL done_extra_resp: got err %0d fail %b expected 1 1", err_count_a, test_fail_a);
    else n_pass++;
  endtask

  task automatic test_wait();
    int tx, fa, sd, td;
    apply_reset_a();
    run_traffic(3, 5, -1, -1, -1, tx, fa, sd, td);
    n_checks++;
    if (tx != 16 || td < 0) $display("FAIL wait_count: got tx %0d done_cyc %0d expected 16 >=0", tx, td);
    else n_pass++;
    n_checks++;
    if (sd - fa != 21) $display("FAIL wait_span: got %0d cycles expected 21", sd - fa);
    else n_pass++;
    n_checks++;
    if (test_fail_a !== 1'b0 || err_count_a !== 16'd0)
      $display("FAIL wait_result: got fail %b err %0d expected 0 0", test_fail_a, err_count_a);
    else n_pass++;
  endtask

  task automatic test_corrupt();
    int tx, fa, sd, td;
    apply_reset_a();
    run_traffic(-1, 0, 7, -1, -1, tx, fa, sd, td);
    n_checks++;
    if (tx != 16 || td < 0) $display("FAIL corrupt_count: got tx %0d done_cyc %0d expected 16 >=0", tx, td);
    else n_pass++;
    n_checks++;
    if (err_count_a !== 16'd1 || test_fail_a !== 1'b1 || test_done_a !== 1'b1)
      $display("FAIL corrupt_result: got err %0d fail %b done %b expected 1 1 1",
               err_count_a, test_fail_a, test_done_a);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int tx, fa, sd, td;
    apply_reset_a();
    run_traffic(-1, 0, -1, 15, -1, tx, fa, sd, td);
    n_checks++;
    if (td < 0 || td - sd != 50)
      $display("FAIL timeout_latency: got %0d cycles (done_cyc %0d) expected 50", td - sd, td);
    else n_pass++;
    n_checks++;
    if ({stim_done_a, test_done_a, test_fail_a, bus_a.stim_access} !== 4'b1110)
      $display("FAIL timeout_flags: got %b expected 1110",
               {stim_done_a, test_done_a, test_fail_a, bus_a.stim_access});
    else n_pass++;
    n_checks++;
    if (err_count_a !== 16'd0) $display("FAIL timeout_err: got %0d expected 0", err_count_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int tx, fa, sd, td;
    apply_reset_a();
    run_traffic(-1, 0, -1, -1, 9, tx, fa, sd, td);
    #1;
    n_checks++;
    if (tx != 9) $display("FAIL abort_point: got tx %0d expected 9", tx);
    else n_pass++;
    n_checks++;
    if ({bus_a.stim_access, dut_active_a, stim_done_a, test_done_a, test_fail_a} !== 5'b0 ||
        bus_a.stim_packet !== 32'h0)
      $display("FAIL abort_outputs: got flags %b packet %0h expected 00000 0",
               {bus_a.stim_access, dut_active_a, stim_done_a, test_done_a, test_fail_a},
               bus_a.stim_packet);
    else n_pass++;
    n_checks++;
    if (state_a !== ST_RESET) $display("FAIL abort_state: got %0d expected %0d", state_a, ST_RESET);
    else n_pass++;
    apply_reset_a();
    run_traffic(-1, 0, -1, -1, -1, tx, fa, sd, td);
    n_checks++;
    if (tx != 16 || td < 0 || test_fail_a !== 1'b0)
      $display("FAIL rerun_result: got tx %0d done_cyc %0d fail %b expected 16 >=0 0", tx, td, test_fail_a);
    else n_pass++;
  endtask

  task automatic test_n_zero();
    int  first;
    bit  saw_access;
    nreset_b = 1'b0;
    start_b  = 1'b0;
    bus_b.stim_wait = 1'b0; bus_b.resp_access = 1'b0; bus_b.resp_packet = '0;
    repeat (2) @(posedge clk);
    #1 nreset_b = 1'b1;
    first = -1;
    saw_access = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (dut_active_b && first < 0) first = k;
      if (bus_b.stim_access) saw_access = 1;
    end
    n_checks++;
    if (first != 4) $display("FAIL nzero_active_cycle: got %0d expected 4", first);
    else n_pass++;
    n_checks++;
    if (stim_done_b !== 1'b0 || test_done_b !== 1'b0)
      $display("FAIL nzero_before_start: got done %b %b expected 0 0", stim_done_b, test_done_b);
    else n_pass++;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({stim_done_b, test_done_b, test_fail_b} !== 3'b110)
      $display("FAIL nzero_done: got %b expected 110", {stim_done_b, test_done_b, test_fail_b});
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (bus_b.stim_access) saw_access = 1;
    end
    n_checks++;
    if (saw_access) $display("FAIL nzero_no_access: got access 1 expected 0");
    else n_pass++;
    bus_b.resp_access = 1'b1;
    bus_b.resp_packet = 32'h1;
    @(posedge clk);
    #1 bus_b.resp_access = 1'b0;
    n_checks++;
    if (err_count_b !== 16'd1 || test_fail_b !== 1'b1)
      $display("FAIL nzero_extra_resp: got err %0d fail %b expected 1 1", err_count_b, test_fail_b);
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    nreset_a = 1'b0; start_a = 1'b0;
    nreset_b = 1'b0; start_b = 1'b0;
    bus_a.stim_wait = 1'b0; bus_a.resp_access = 1'b0; bus_a.resp_packet = '0;
    bus_b.stim_wait = 1'b0; bus_b.resp_access = 1'b0; bus_b.resp_packet = '0;
    test_reset();
    test_basic();
    test_wait();
    test_corrupt();
    test_timeout();
    test_reset_mid();
    test_n_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
